// File: rtl/robsmult_param.sv
// Sequential Robertson shift-add multiplier, signed or unsigned per operation; W+1 clocks start-to-done.
// No backpressure: ready drops while an operation runs, and a start seen while ready is low is dropped.
module robsmult_param #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [W-1:0]   multiplier,
  input  logic [W-1:0]   multiplicand,
  output logic           ready,
  output logic [2*W-1:0] product,
  output logic           done
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W:0]    acc;
  logic [W-1:0]  q;
  logic [W-1:0]  mcand;
  logic          smode;
  logic [CW-1:0] cnt;

  logic [W:0]    ext;
  logic [W:0]    sum;
  logic          last;

  // The final step subtracts in signed mode: the multiplier's MSB has negative weight.
  always_comb begin
    ext  = smode ? {mcand[W-1], mcand} : {1'b0, mcand};
    last = (cnt == CW'(1));
    sum  = acc;
    if (q[0]) begin
      sum = (last && smode) ? (acc - ext) : (acc + ext);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      q       <= '0;
      mcand   <= '0;
      smode   <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            q     <= multiplier;
            mcand <= multiplicand;
            smode <= signed_mode;
            cnt   <= CW'(W);
            ready <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          // Unsigned: the W+1-bit sum's carry drops into bit W-1 and a zero fills the top.
          acc <= {smode & sum[W], sum[W:1]};
          q   <= {sum[0], q[W-1:1]};
          cnt <= cnt - CW'(1);
          if (last) begin
            ready <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          product <= {acc[W-1:0], q};
          done    <= 1'b1;
          if (start) begin
            acc   <= '0;
            q     <= multiplier;
            mcand <= multiplicand;
            smode <= signed_mode;
            cnt   <= CW'(W);
            ready <= 1'b0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
